mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum cycles to wait for mem_ack per transaction (range 1..255).
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  request one access; sampled only in IDLE.
REQ-005 we  in  1  1 = store, 0 = load; sampled with start.
REQ-006 size  in  2  00 byte, 01 half, 10 word, 11 treated as word; sampled with start.
REQ-007 sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend; sampled with start.
REQ-008 addr  in  32  byte address, driven from the ALU result register; sampled with start.
REQ-009 wdata  in  32  store data, right-aligned; sampled with start.
REQ-010 busy  out  1  high whenever state is not IDLE.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 err  out  1  completion status: misaligned or timeout; valid with done.
REQ-013 rdata  out  32  load result (memory data register).
REQ-014 mem_req  out  1  bus request, held until ack or timeout.
REQ-015 mem_we  out  1  bus write enable.
REQ-016 mem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
REQ-017 mem_be  out  4  byte enables, little-endian lanes.
REQ-018 mem_wdata  out  32  lane-replicated store data.
REQ-019 mem_rdata  in  32  bus read data, valid when mem_ack = 1.
REQ-020 mem_ack  in  1  bus completion; takes effect only while in BUS.

Function
REQ-021 The FSM SHALL have states IDLE, BUS and DONE; all outputs registered.
REQ-022 IDLE with start=1 and aligned access SHALL latch we/size/sign_ext/addr/wdata, go to BUS and assert mem_req on the next cycle.
REQ-023 Alignment: half needs addr[0]=0, word/11 needs addr[1:0]=00; misaligned start SHALL go IDLE->DONE with err=1, no mem_req and no rdata change.
REQ-024 mem_be: byte = 4'b0001<<addr[1:0]; half = addr[1] ? 1100 : 0011; word = 1111; mem_be SHALL be 0000 when mem_req=0.
REQ-025 mem_wdata: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
REQ-026 In BUS with mem_ack=1: a load SHALL capture the selected lane of mem_rdata, extended per sign_ext to 32 bits, into rdata; mem_req SHALL drop; next state DONE with err=0.
REQ-027 A BUS cycle counter SHALL reset on entry to BUS; if TIMEOUT cycles elapse without ack, mem_req SHALL drop and next state DONE with err=1, rdata unchanged.
REQ-028 mem_ack on the same edge that the counter reaches TIMEOUT SHALL count as success.
REQ-029 DONE SHALL assert done for exactly one cycle, then return to IDLE; start in DONE is ignored.
REQ-030 start in BUS or DONE SHALL be ignored and must not alter the latched fields.
REQ-031 Latency: start at edge 0 -> mem_req high after edge 0; ack seen at edge k (k>=1) -> done high after edge k for one cycle; minimum start-to-done is 2 cycles.
REQ-032 mem_ack outside BUS SHALL be ignored.
REQ-033 err SHALL hold its value until the next accepted start, which clears it.
REQ-034 rdata SHALL hold its value until the next successful load; stores and errors leave it unchanged.

Reset
REQ-035 rst=1 SHALL immediately force IDLE, with busy, done, err, mem_req, mem_we = 0, mem_be = 0000, and mem_addr, mem_wdata, rdata = 0.
REQ-036 Reset during BUS SHALL drop mem_req without waiting for the clock; the in-flight access is abandoned with no done pulse.

Verification
REQ-037 Word load: addr=0x100, mem_rdata=0xDEADBEEF, ack 1 cycle after req -> mem_addr=0x100, mem_be=1111, done one cycle, rdata=0xDEADBEEF, err=0.
REQ-038 Byte load sign_ext=1: addr=0x103, mem_rdata=0x80000000 -> mem_be=1000, rdata=0xFFFFFF80; with sign_ext=0 -> rdata=0x00000080.
REQ-039 Half store: addr=0x22, wdata=0x1234ABCD -> mem_we=1, mem_addr=0x20, mem_be=1100, mem_wdata=0xABCDABCD, rdata unchanged.
REQ-040 Misaligned word load at addr=0x101 -> no mem_req, done after 1 cycle with err=1.
REQ-041 No ack, TIMEOUT=4 -> mem_req high exactly 4 cycles, then done with err=1; start pulses during BUS ignored.
REQ-042 rst asserted mid-BUS -> mem_req falls before the next clock edge, no done pulse; after release a new start completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Sequences one load or store onto a simple req/ack memory bus.
//   Each access is either a byte, a half-word or a word.
//   Sub-word accesses are mapped onto little-endian byte lanes.
//   Load data is extracted from its lane and then sign- or zero-extended.
//
// Parameters
//   TIMEOUT   : maximum BUS cycles to wait for mem_ack (1..255)
//
// Ports
//   clk, rst  : clock, asynchronous active-high reset
//   start     : request an access (sampled in IDLE only)
//   we        : 1 = store, 0 = load
//   size      : 00 byte, 01 half, 10/11 word
//   sign_ext  : load extension mode
//   addr      : byte address
//   wdata     : right-aligned store data
//   busy      : state != IDLE
//   done      : one-cycle completion pulse
//   err       : completion status (misaligned or timeout), held until next start
//   rdata     : last successful load result
//   mem_*     : bus request side (req/we/addr/be/wdata out, rdata/ack in)
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_DONE
  } state_t;

  state_t      state_q, state_d;

  logic [7:0]  cnt_q;
  logic        we_q;
  logic        sx_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [3:0]  be_q;
  logic        err_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        aligned;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic        timeout_hit;
  logic [31:0] lane;
  logic [31:0] load_val;

  // Request-side decode of the incoming access.
  always_comb begin
    aligned   = 1'b1;
    be_new    = 4'b1111;
    wdata_new = wdata;
    case (size)
      2'b00: begin
        be_new    = 4'b0001 << addr[1:0];
        wdata_new = {4{wdata[7:0]}};
      end
      2'b01: begin
        aligned   = ~addr[0];
        be_new    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{wdata[15:0]}};
      end
      default: begin
        aligned   = (addr[1:0] == 2'b00);
        be_new    = 4'b1111;
        wdata_new = wdata;
      end
    endcase
  end

  // This edge would be the TIMEOUT-th BUS cycle without an ack.
  assign timeout_hit = ({24'd0, cnt_q} + 32'd1) == TIMEOUT;

  // Load path: shift the addressed lane down, then extend.
  always_comb begin
    lane = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_val = {{24{sx_q & lane[7]}}, lane[7:0]};
      2'b01:   load_val = {{16{sx_q & lane[15]}}, lane[15:0]};
      default: load_val = lane;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = aligned ? S_BUS : S_DONE;
      S_BUS:   if (mem_ack || timeout_hit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are pure decodes of registers. Reset clears state_q
  // asynchronously, so mem_req drops without waiting for a clock edge.
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    mem_req   = (state_q == S_BUS);
    mem_be    = mem_req ? be_q : 4'b0000;
    mem_we    = we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    err       = err_q;
    rdata     = rdata_q;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sx_q    <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            err_q <= ~aligned;
            // A misaligned access never reaches the bus, so the
            // bus-facing fields keep their previous values.
            if (aligned) begin
              cnt_q   <= '0;
              we_q    <= we;
              sx_q    <= sign_ext;
              size_q  <= size;
              off_q   <= addr[1:0];
              be_q    <= be_new;
              addr_q  <= {addr[31:2], 2'b00};
              wdata_q <= wdata_new;
            end
          end
        end
        S_BUS: begin
          cnt_q <= cnt_q + 8'd1;
          // An ack on the final allowed cycle still wins over the timeout.
          if (mem_ack) begin
            if (!we_q) rdata_q <= load_val;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
